// File: rtl/multiplicador_sec_if.sv
// Request/response bundle of the sequential multiplier: operands and start in,
// registered product with busy/done status out.
interface multiplicador_sec_if #(parameter int N = 6);
    logic           start;
    logic [N-1:0]   num1;
    logic [N-1:0]   num2;
    logic [2*N-1:0] result;
    logic           busy;
    logic           done;

    modport master (output start, num1, num2, input result, busy, done);
    modport slave  (input start, num1, num2, output result, busy, done);
endinterface

// File: rtl/multiplicador_sec.sv
// Unsigned shift-and-add multiplier: one adder pass per multiplier bit,
// N iterations plus one FIN cycle that pulses done with the product.
module sumador #(parameter int N = 6) (
    input  logic [N-1:0] num1,
    input  logic [N-1:0] num2,
    input  logic         c_1,
    output logic [N-1:0] result,
    output logic         c_o
);
    assign {c_o, result} = {1'b0, num1} + {1'b0, num2} + {{N{1'b0}}, c_1};
endmodule

module multiplicador_sec #(parameter int N = 6) (
    input  logic             clk,
    input  logic             rst,
    multiplicador_sec_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t         state, state_next;
    logic [N-1:0]   a, p, q;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   add_b, add_sum;
    logic           add_co;
    logic [N:0]     s;

    assign add_b = q[0] ? a : '0;

    sumador #(.N(N)) u_sumador (
        .num1   (p),
        .num2   (add_b),
        .c_1    (1'b0),
        .result (add_sum),
        .c_o    (add_co)
    );

    assign s = {add_co, add_sum};

    // NOTE: state and datapath registers use <= so every flop samples the
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: default first, so no path through the case leaves a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == CALC) || (state == FIN);
        bus.done = (state == FIN);
    end

    // {P,Q} <= {S,Q} >> 1: carry lands in P[N-1], S[0] in Q[N-1].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a          <= '0;
            p          <= '0;
            q          <= '0;
            cnt        <= '0;
            bus.result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a   <= bus.num1;
                        q   <= bus.num2;
                        p   <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    p   <= s[N:1];
                    q   <= {s[0], q[N-1:1]};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) bus.result <= {s[N:1], s[0], q[N-1:1]};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multiplicador_sec.sv
// Scoreboard bench for multiplicador_sec: products queued at start, popped at
// each done and checked together with latency, pulse width and result hold.
module tb_multiplicador_sec;
    localparam int N = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    logic [2*N-1:0] exp_q[$];

    always #5 clk = ~clk;

    multiplicador_sec_if #(.N(N)) bus ();

    multiplicador_sec #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [2*N-1:0] prod(input logic [N-1:0] x, input logic [N-1:0] y);
        return (2*N)'(x) * (2*N)'(y);
    endfunction

    task automatic pop_compare(input string name);
        logic [2*N-1:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: done with empty scoreboard, result=%0d", name, bus.result);
        end else begin
            e = exp_q.pop_front();
            if (bus.result !== e) begin
                errors++;
                $display("FAIL %s: result=%0d expected=%0d", name, bus.result, e);
            end
        end
    endtask

    // One full operation; inputs driven at negedge, outputs sampled at negedge.
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input string name);
        logic [2*N-1:0] prev;
        int  lat;
        bit  seen, stable;
        prev = bus.result;
        @(negedge clk);
        bus.start = 1'b1; bus.num1 = x; bus.num2 = y;
        exp_q.push_back(prod(x, y));
        @(negedge clk);
        bus.start = 1'b0;
        bus.num1 = N'($urandom); bus.num2 = N'($urandom);
        seen = 0; stable = 1; lat = -1;
        for (int i = 0; i < N + 4 && !seen; i++) begin
            if (bus.done) begin
                seen = 1; lat = i;
            end else begin
                if (bus.result !== prev || bus.busy !== 1'b1) stable = 0;
                @(negedge clk);
            end
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, N + 4);
            void'(exp_q.pop_front());
            return;
        end
        pop_compare(name);
        vectors++;
        if (lat != N) begin
            errors++;
            $display("FAIL %s_latency: latency=%0d expected=%0d", name, lat, N);
        end
        vectors++;
        if (!stable) begin
            errors++;
            $display("FAIL %s_hold: result changed or busy low before done", name);
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_width: done=%b busy=%b expected done=0 busy=0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.num1 = '0; bus.num2 = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.result !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset: result=%0d busy=%b done=%b expected 0/0/0", bus.result, bus.busy, bus.done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op(6'd63, 6'd63, "mul_63x63");
        run_op(6'd63, 6'd2,  "mul_63x2");
        run_op(6'd63, 6'd0,  "mul_63x0");
    endtask

    task automatic test_start_ignored();
        int dones;
        @(negedge clk);
        bus.start = 1'b1; bus.num1 = 6'd5; bus.num2 = 6'd7;
        exp_q.push_back(prod(6'd5, 6'd7));
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < N + 8; i++) begin
            if (i == 2) begin bus.start = 1'b1; bus.num1 = 6'd60; bus.num2 = 6'd3; end
            if (i == 3) bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                pop_compare("ignored_start_result");
            end
            @(negedge clk);
        end
        vectors++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ignored_start_dones: dones=%0d expected=1", dones);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        bus.start = 1'b1; bus.num1 = 6'd60; bus.num2 = 6'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.result !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: result=%0d busy=%b done=%b expected 0/0/0", bus.result, bus.busy, bus.done);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        vectors++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_mid_nodone: dones=%0d expected=0", dones);
        end
        run_op(6'd60, 6'd3, "after_reset_60x3");
    endtask

    task automatic test_back_to_back();
        int  first_at, second_at;
        bit  held;
        @(negedge clk);
        bus.start = 1'b1; bus.num1 = 6'd63; bus.num2 = 6'd5;
        exp_q.push_back(prod(6'd63, 6'd5));
        exp_q.push_back(prod(6'd1, 6'd1));
        @(negedge clk);
        bus.num1 = 6'd1; bus.num2 = 6'd1;
        first_at = -1; second_at = -1; held = 1;
        for (int i = 0; i < 3 * N + 6 && second_at < 0; i++) begin
            if (first_at >= 0 && !bus.done && bus.result !== prod(6'd63, 6'd5)) held = 0;
            if (bus.done) begin
                if (first_at < 0) begin
                    first_at = i;
                    pop_compare("b2b_first");
                end else begin
                    second_at = i;
                    bus.start = 1'b0;
                    pop_compare("b2b_second");
                end
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        vectors++;
        if (first_at != N || second_at != 2 * N + 2) begin
            errors++;
            $display("FAIL b2b_timing: dones at %0d,%0d expected %0d,%0d", first_at, second_at, N, 2 * N + 2);
        end
        vectors++;
        if (!held) begin
            errors++;
            $display("FAIL b2b_hold: result left 315 before second completion");
        end
        exp_q.delete();
        repeat (N + 3) @(negedge clk);
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++)
            run_op(N'($urandom), N'($urandom), "random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
